unidad_control_acum: RTL and testbench

FSM controller that sequences the register-file/ALU datapath (WIDTH-bit data, NUMREG registers) to compute the accumulated sum 1+2+...+N into a selected destination register.
- Accepts a start request with N and a destination index.
- Clears the destination register, then issues one add-immediate write per iteration.
- Raises a one-cycle completion pulse.
- Sits between the top-level start/finish handshake and the datapath's write-enable, address and ALU-select inputs.

---
 rtl/unidad_control_acum.sv | 118 +++++++++++
 tb/tb_unidad_control_acum.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidad_control_acum.sv
// Controller that drives the register-file/ALU datapath to accumulate 1+2+...+N
// into a chosen destination register, with a start/finish handshake.
module unidad_control_acum #(
    parameter  int WIDTH      = 32,
    parameter  int NUMREG     = 16,
    parameter  int CNT_W      = 8,
    localparam int INDEX_SIZE = $clog2(NUMREG)
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  inicio_i,
    input  logic [CNT_W-1:0]      n_i,
    input  logic [INDEX_SIZE-1:0] dst_i,
    output logic                  ocupado_o,
    output logic                  fin_o,
    output logic                  we_o,
    output logic [INDEX_SIZE-1:0] waddr_o,
    output logic [INDEX_SIZE-1:0] raddr_o,
    output logic [1:0]            alu_op_o,
    output logic                  sel_imm_o,
    output logic [WIDTH-1:0]      imm_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACUM  = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ALU_PASS_B = 2'b00;
    localparam logic [1:0] ALU_ADD    = 2'b01;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [INDEX_SIZE-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (inicio_i) begin
                    n_d     = n_i;
                    dst_d   = dst_i;
                    cnt_d   = CNT_W'(1);
                    state_d = CLEAR;
                end
            end
            CLEAR: state_d = (n_q == '0) ? DONE : ACUM;
            // Counter stops at n_q, so it never wraps even for the largest N.
            ACUM: begin
                if (cnt_q == n_q) state_d = DONE;
                else              cnt_d   = cnt_q + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: decoded only from registered state.
    always_comb begin
        ocupado_o = 1'b0;
        fin_o     = 1'b0;
        we_o      = 1'b0;
        waddr_o   = '0;
        raddr_o   = '0;
        alu_op_o  = ALU_PASS_B;
        sel_imm_o = 1'b0;
        imm_o     = '0;
        unique case (state_q)
            IDLE: ;
            CLEAR: begin
                ocupado_o = 1'b1;
                we_o      = 1'b1;
                waddr_o   = dst_q;
                alu_op_o  = ALU_PASS_B;
                sel_imm_o = 1'b1;
            end
            ACUM: begin
                ocupado_o = 1'b1;
                we_o      = 1'b1;
                waddr_o   = dst_q;
                raddr_o   = dst_q;
                alu_op_o  = ALU_ADD;
                sel_imm_o = 1'b1;
                imm_o     = WIDTH'(cnt_q);
            end
            DONE: begin
                ocupado_o = 1'b1;
                fin_o     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_unidad_control_acum.sv
// Self-checking bench for unidad_control_acum: cycle traces against a timeline
// model, plus a datapath register model that must end at N(N+1)/2.
module tb_unidad_control_acum;

    localparam int WIDTH  = 32;
    localparam int NUMREG = 16;
    localparam int CNT_W  = 8;
    localparam int IDX    = $clog2(NUMREG);

    logic             clk = 1'b0;
    logic             rstn;
    logic             inicio;
    logic [CNT_W-1:0] n_in;
    logic [IDX-1:0]   dst_in;
    logic             ocupado_o, fin_o, we_o, sel_imm_o;
    logic [IDX-1:0]   waddr_o, raddr_o;
    logic [1:0]       alu_op_o;
    logic [WIDTH-1:0] imm_o;

    always #5 clk = ~clk;

    unidad_control_acum #(
        .WIDTH (WIDTH),
        .NUMREG(NUMREG),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i    (clk),
        .rstn_i   (rstn),
        .inicio_i (inicio),
        .n_i      (n_in),
        .dst_i    (dst_in),
        .ocupado_o(ocupado_o),
        .fin_o    (fin_o),
        .we_o     (we_o),
        .waddr_o  (waddr_o),
        .raddr_o  (raddr_o),
        .alu_op_o (alu_op_o),
        .sel_imm_o(sel_imm_o),
        .imm_o    (imm_o)
    );

    typedef struct packed {
        logic             ocupado;
        logic             fin;
        logic             we;
        logic [IDX-1:0]   waddr;
        logic [IDX-1:0]   raddr;
        logic [1:0]       alu_op;
        logic             sel_imm;
        logic [WIDTH-1:0] imm;
    } out_t;

    int compared   = 0;
    int mismatched = 0;

    logic [WIDTH-1:0] regs [NUMREG] = '{default: 32'hDEAD_BEEF};
    logic             fin_prev = 1'b0;

    // Datapath model: applies the write the controller requests for this cycle,
    // and watches the run-wide invariants.
    always @(negedge clk) begin
        logic [WIDTH-1:0] b;
        if (rstn === 1'b1) begin
            compared++;
            if (fin_o && fin_prev) begin
                $display("FAIL fin_two_cycles: fin_o=1 on consecutive cycles");
                mismatched++;
            end
            compared++;
            if (we_o && (fin_o || !ocupado_o)) begin
                $display("FAIL we_outside_run: we_o=%b fin_o=%b ocupado_o=%b required we_o=0",
                         we_o, fin_o, ocupado_o);
                mismatched++;
            end
            fin_prev = fin_o;
            if (we_o) begin
                b = sel_imm_o ? imm_o : '0;
                regs[waddr_o] = (alu_op_o == 2'b01) ? regs[raddr_o] + b : b;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t sample();
        out_t s;
        s.ocupado = ocupado_o;
        s.fin     = fin_o;
        s.we      = we_o;
        s.waddr   = waddr_o;
        s.raddr   = raddr_o;
        s.alu_op  = alu_op_o;
        s.sel_imm = sel_imm_o;
        s.imm     = imm_o;
        return s;
    endfunction

    // Expected outputs t cycles after the start edge: CLEAR at t=0,
    // ACUM adding t for t=1..n, DONE at t=n+1, idle otherwise.
    function automatic out_t expect_at(int t, int n, int dst);
        out_t e;
        e = '0;
        if (t == 0) begin
            e.ocupado = 1'b1;
            e.we      = 1'b1;
            e.waddr   = IDX'(dst);
            e.sel_imm = 1'b1;
        end else if (t >= 1 && t <= n) begin
            e.ocupado = 1'b1;
            e.we      = 1'b1;
            e.waddr   = IDX'(dst);
            e.raddr   = IDX'(dst);
            e.alu_op  = 2'b01;
            e.sel_imm = 1'b1;
            e.imm     = WIDTH'(t);
        end else if (t == n + 1) begin
            e.ocupado = 1'b1;
            e.fin     = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] tri_sum(int n);
        longint s;
        s = (longint'(n) * longint'(n + 1)) / 2;
        return WIDTH'(s);
    endfunction

    task automatic test_reset();
        out_t obs;
        rstn   = 1'b0;
        inicio = 1'b1;
        n_in   = 8'd5;
        dst_in = 4'd1;
        #2;
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL reset_outputs: got %h required 0", obs);
            mismatched++;
        end
        tick();
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL reset_ignores_inicio: got %h required 0", obs);
            mismatched++;
        end
        inicio = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL idle_after_reset: got %h required 0", obs);
            mismatched++;
        end
    endtask

    task automatic test_n6();
        out_t obs, exp;
        n_in = 8'd6; dst_in = 4'd0; inicio = 1'b1;
        tick();
        inicio = 1'b0;
        for (int t = 0; t <= 7; t++) begin
            obs = sample();
            exp = expect_at(t, 6, 0);
            compared++;
            if (obs !== exp) begin
                $display("FAIL n6_trace t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            tick();
            if (t >= 1 && t <= 6) begin
                compared++;
                if (regs[0] !== tri_sum(t)) begin
                    $display("FAIL n6_partial t=%0d: got %0d required %0d", t, regs[0], tri_sum(t));
                    mismatched++;
                end
            end
        end
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL n6_idle_after: got %h required 0", obs);
            mismatched++;
        end
        compared++;
        if (regs[0] !== 32'd21) begin
            $display("FAIL n6_sum: got %0d required 21", regs[0]);
            mismatched++;
        end
    endtask

    task automatic test_n0();
        out_t obs, exp;
        n_in = 8'd0; dst_in = 4'd3; inicio = 1'b1;
        tick();
        inicio = 1'b0;
        for (int t = 0; t <= 2; t++) begin
            obs = sample();
            exp = expect_at(t, 0, 3);
            compared++;
            if (obs !== exp) begin
                $display("FAIL n0_trace t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            tick();
        end
        compared++;
        if (regs[3] !== 32'd0) begin
            $display("FAIL n0_sum: got %0d required 0", regs[3]);
            mismatched++;
        end
    endtask

    task automatic test_nmax();
        out_t obs, exp;
        n_in = 8'd255; dst_in = 4'd15; inicio = 1'b1;
        tick();
        inicio = 1'b0;
        for (int t = 0; t <= 257; t++) begin
            obs = sample();
            exp = expect_at(t, 255, 15);
            compared++;
            if (obs !== exp) begin
                $display("FAIL nmax_trace t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            tick();
        end
        compared++;
        if (regs[15] !== 32'd32640) begin
            $display("FAIL nmax_sum: got %0d required 32640", regs[15]);
            mismatched++;
        end
    endtask

    task automatic test_hold_inicio();
        out_t obs, exp;
        n_in = 8'd3; dst_in = 4'd5; inicio = 1'b1;
        tick();
        n_in = 8'd200; dst_in = 4'd7;
        for (int t = 0; t <= 4; t++) begin
            obs = sample();
            exp = expect_at(t, 3, 5);
            compared++;
            if (obs !== exp) begin
                $display("FAIL hold_run1 t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            tick();
        end
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL hold_gap_idle: got %h required 0", obs);
            mismatched++;
        end
        n_in = 8'd2; dst_in = 4'd9;
        tick();
        for (int t = 0; t <= 3; t++) begin
            obs = sample();
            exp = expect_at(t, 2, 9);
            compared++;
            if (obs !== exp) begin
                $display("FAIL hold_run2 t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            inicio = 1'b0;
            n_in   = 8'd77;
            tick();
        end
        compared++;
        if (regs[5] !== 32'd6 || regs[9] !== 32'd3) begin
            $display("FAIL hold_sums: got %0d/%0d required 6/3", regs[5], regs[9]);
            mismatched++;
        end
    endtask

    task automatic test_async_reset();
        out_t obs, exp;
        n_in = 8'd6; dst_in = 4'd2; inicio = 1'b1;
        tick();
        inicio = 1'b0;
        for (int t = 0; t <= 3; t++) begin
            obs = sample();
            exp = expect_at(t, 6, 2);
            compared++;
            if (obs !== exp) begin
                $display("FAIL areset_pre t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            if (t < 3) tick();
        end
        #2 rstn = 1'b0;
        #1;
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL areset_immediate: got %h required 0", obs);
            mismatched++;
        end
        tick();
        @(negedge clk);
        rstn = 1'b1;
        fin_prev = 1'b0;
        tick();
        obs = sample();
        compared++;
        if (obs !== out_t'('0)) begin
            $display("FAIL areset_idle_after: got %h required 0", obs);
            mismatched++;
        end
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        for (int t = 0; t <= 8; t++) begin
            obs = sample();
            exp = expect_at(t, 6, 2);
            compared++;
            if (obs !== exp) begin
                $display("FAIL areset_rerun t=%0d: got %h required %h", t, obs, exp);
                mismatched++;
            end
            tick();
        end
        compared++;
        if (regs[2] !== 32'd21) begin
            $display("FAIL areset_sum: got %0d required 21", regs[2]);
            mismatched++;
        end
    endtask

    task automatic test_random();
        out_t obs, exp;
        int   n, dst, gap;
        for (int r = 0; r < 12; r++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                n_in   = CNT_W'($urandom);
                dst_in = IDX'($urandom);
                tick();
                obs = sample();
                compared++;
                if (obs !== out_t'('0)) begin
                    $display("FAIL rand_idle r=%0d: got %h required 0", r, obs);
                    mismatched++;
                end
            end
            n   = int'($urandom_range(0, 30));
            dst = int'($urandom_range(0, NUMREG - 1));
            n_in = CNT_W'(n); dst_in = IDX'(dst); inicio = 1'b1;
            tick();
            inicio = 1'b0;
            for (int t = 0; t <= n + 2; t++) begin
                obs = sample();
                exp = expect_at(t, n, dst);
                compared++;
                if (obs !== exp) begin
                    $display("FAIL rand_trace r=%0d n=%0d t=%0d: got %h required %h", r, n, t, obs, exp);
                    mismatched++;
                end
                n_in   = CNT_W'($urandom);
                dst_in = IDX'($urandom);
                if (t < n + 2) tick();
            end
            compared++;
            if (regs[dst] !== tri_sum(n)) begin
                $display("FAIL rand_sum r=%0d n=%0d: got %0d required %0d", r, n, regs[dst], tri_sum(n));
                mismatched++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_n6();
        test_n0();
        test_nmax();
        test_hold_inicio();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
